// File: rtl/seg7_pkg.sv
// Shared definitions for the active-low 7-segment display path.
//   GLYPHS  : active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0-F,
//             indexed by digit value. The segment encoder uses the same table.
//   state_t : scan-reader FSM states.
package seg7_pkg;

    localparam logic [15:0][6:0] GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

endpackage

// File: rtl/seg7_glyph_decoder.sv
// Combinational reverse lookup of an active-low 7-segment pattern.
//   code  in  7  segment pattern {g,f,e,d,c,b,a}, active-low
//   value out 4  hex digit shown (0 when the pattern is not a glyph)
//   err   out 1  pattern matched none of the 16 glyphs
module seg7_glyph_decoder
    import seg7_pkg::*;
(
    input  logic [6:0] code,
    output logic [3:0] value,
    output logic       err
);

    // Glyphs are unique, so at most one iteration can match.
    always_comb begin
        value = 4'h0;
        err   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (code == GLYPHS[i]) begin
                value = 4'(i);
                err   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reader for a time-multiplexed active-low 7-segment display bus. Each
// {anode, code} pair must be stable for STABLE_CYCLES registered samples before
// it is captured into a shadow frame; once every digit has been captured the
// shadow is published and frame_valid pulses for one cycle.
//   clock       in  system clock
//   reset       in  synchronous active-high reset
//   anode_n     in  digit select, active-low, one-hot-low when valid
//   seg_code    in  {dp,g,f,e,d,c,b,a}, active-low
//   digit_value out nibble per digit, digit i at [4i+3:4i]
//   digit_dp    out decimal point lit per digit
//   digit_err   out captured pattern was not a glyph
//   frame_valid out one-cycle pulse when a new snapshot is presented
//   err_count   out (only with SEG7_SCAN_ERR_CNT_EN) saturating count of
//                   captures that were not glyphs
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 8,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   anode_n,
    input  logic [7:0]              seg_code,
    output logic [4*NUM_DIGITS-1:0] digit_value,
    output logic [NUM_DIGITS-1:0]   digit_dp,
    output logic [NUM_DIGITS-1:0]   digit_err,
`ifdef SEG7_SCAN_ERR_CNT_EN
    output logic [15:0]             err_count,
`endif
    output logic                    frame_valid
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [NUM_DIGITS-1:0] ONE_D = NUM_DIGITS'(1);

    // Input stage and the previous registered pair for change detection.
    logic [NUM_DIGITS-1:0] s_anode, prev_anode;
    logic [7:0]            s_code, prev_code;

    always_ff @(posedge clock) begin
        if (reset) begin
            s_anode    <= '1;
            s_code     <= 8'hFF;
            prev_anode <= '1;
            prev_code  <= 8'hFF;
        end else begin
            s_anode    <= anode_n;
            s_code     <= seg_code;
            prev_anode <= s_anode;
            prev_code  <= s_code;
        end
    end

    logic [NUM_DIGITS-1:0] sel;
    logic                  digit_ok;
    logic                  same;

    assign sel      = ~s_anode;
    assign digit_ok = (sel != '0) && ((sel & (sel - ONE_D)) == '0);
    assign same     = (s_anode == prev_anode) && (s_code == prev_code);

    // FSM
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             capture;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (digit_ok) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (!digit_ok) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (same) begin
                    cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
                end else begin
                    cnt_d = CNT_ONE;
                end
            end
            HOLD: begin
                if (!same) begin
                    if (digit_ok) begin
                        state_d = SETTLE;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // A pair whose count reaches the dwell is captured on this same edge,
        // which also covers STABLE_CYCLES == 1 on the first stable sample.
        if (state_d == SETTLE && cnt_d >= CNT_MAX) begin
            capture = 1'b1;
            state_d = HOLD;
        end
    end

    // Capture datapath
    logic [3:0] dec_value;
    logic       dec_err;

    seg7_glyph_decoder u_glyph (
        .code  (s_code[6:0]),
        .value (dec_value),
        .err   (dec_err)
    );

    logic [4*NUM_DIGITS-1:0] shadow_value, merged_value;
    logic [NUM_DIGITS-1:0]   shadow_dp, merged_dp;
    logic [NUM_DIGITS-1:0]   shadow_err, merged_err;
    logic [NUM_DIGITS-1:0]   seen, seen_cur;
    logic                    frame_done;

    // Shadow with the current capture folded in, so a completing capture is
    // published together with the rest of the frame.
    always_comb begin
        merged_value = shadow_value;
        merged_dp    = shadow_dp;
        merged_err   = shadow_err;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (capture && sel[i]) begin
                merged_value[4*i +: 4] = dec_value;
                merged_dp[i]           = ~s_code[7];
                merged_err[i]          = dec_err;
            end
        end
    end

    assign seen_cur   = capture ? (seen | sel) : seen;
    assign frame_done = capture && (&seen_cur);

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_err   <= '0;
            seen         <= '0;
            digit_value  <= '0;
            digit_dp     <= '0;
            digit_err    <= '0;
            frame_valid  <= 1'b0;
        end else begin
            shadow_value <= merged_value;
            shadow_dp    <= merged_dp;
            shadow_err   <= merged_err;
            frame_valid  <= frame_done;
            if (frame_done) begin
                seen        <= '0;
                digit_value <= merged_value;
                digit_dp    <= merged_dp;
                digit_err   <= merged_err;
            end else begin
                seen <= seen_cur;
            end
        end
    end

`ifdef SEG7_SCAN_ERR_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            err_count <= '0;
        end else if (capture && dec_err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder (NUM_DIGITS=2, STABLE_CYCLES=4):
// a table of directed steps with hand-derived expectations, hand-written reset
// sequences, then random traffic checked every cycle against a run-length
// reference model.
module tb_seg7_scan_decoder;

    localparam int ND = 2;
    localparam int SC = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [ND-1:0] anode_n;
    logic [7:0]    seg_code;
    logic [4*ND-1:0] digit_value;
    logic [ND-1:0] digit_dp, digit_err;
    logic          frame_valid;
`ifdef SEG7_SCAN_ERR_CNT_EN
    logic [15:0]   err_count;
`endif

    seg7_scan_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .anode_n     (anode_n),
        .seg_code    (seg_code),
        .digit_value (digit_value),
        .digit_dp    (digit_dp),
        .digit_err   (digit_err),
`ifdef SEG7_SCAN_ERR_CNT_EN
        .err_count   (err_count),
`endif
        .frame_valid (frame_valid)
    );

    always #5 clock = ~clock;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_tests = 0;
    int n_fail  = 0;
    int frames  = 0;

    // ---------------- reference model ----------------
    logic [ND-1:0]   m_an, p_an;
    logic [7:0]      m_code, p_code;
    int              run;
    logic [3:0]      sh_val [ND];
    logic            sh_dp [ND];
    logic            sh_err [ND];
    logic [ND-1:0]   m_seen;
    logic [4*ND-1:0] e_val;
    logic [ND-1:0]   e_dp, e_err;
    logic            m_fv;
    int              m_errs;

    function automatic int digit_of(input logic [ND-1:0] an);
        int d;
        d = -1;
        if ($countones(~an) == 1) begin
            for (int i = 0; i < ND; i++) if (!an[i]) d = i;
        end
        return d;
    endfunction

    function automatic void decode(input logic [6:0] c, output logic [3:0] v,
                                   output logic e);
        v = 4'h0;
        e = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (glyph[i] == c) begin
                v = 4'(i);
                e = 1'b0;
            end
        end
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_an = '1; p_an = '1; m_code = 8'hFF; p_code = 8'hFF;
            run = 0; m_seen = '0; m_fv = 1'b0; m_errs = 0;
            e_val = '0; e_dp = '0; e_err = '0;
            for (int i = 0; i < ND; i++) begin
                sh_val[i] = 4'h0; sh_dp[i] = 1'b0; sh_err[i] = 1'b0;
            end
        end else begin
            int d;
            logic [3:0] v;
            logic e;
            m_fv = 1'b0;
            if (m_an == p_an && m_code == p_code) run++;
            else run = 1;
            p_an = m_an;
            p_code = m_code;
            d = digit_of(m_an);
            if (d >= 0 && run == SC) begin
                decode(m_code[6:0], v, e);
                sh_val[d] = v;
                sh_dp[d]  = ~m_code[7];
                sh_err[d] = e;
                m_seen[d] = 1'b1;
                if (e && m_errs < 65535) m_errs++;
                if (&m_seen) begin
                    for (int i = 0; i < ND; i++) begin
                        e_val[4*i +: 4] = sh_val[i];
                        e_dp[i]  = sh_dp[i];
                        e_err[i] = sh_err[i];
                    end
                    m_seen = '0;
                    m_fv = 1'b1;
                end
            end
            m_an = anode_n;
            m_code = seg_code;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (frame_valid === 1'b1) frames++;
        check("model_outputs", 32'({digit_err, digit_dp, digit_value}),
              32'({e_err, e_dp, e_val}));
        check("model_frame_valid", 32'(frame_valid), 32'(m_fv));
`ifdef SEG7_SCAN_ERR_CNT_EN
        check("model_err_count", 32'(err_count), 32'(m_errs));
`endif
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        frames = 0;
    endtask

    task automatic drive(input logic [ND-1:0] an, input logic [7:0] code, input int cyc);
        anode_n = an;
        seg_code = code;
        repeat (cyc) tick();
    endtask

    task automatic expect_out(input string name, input logic [7:0] val, input logic [1:0] dp,
                              input logic [1:0] err, input int nfr, input int errs);
        check({name, "_value"}, 32'(digit_value), 32'(val));
        check({name, "_dp"}, 32'(digit_dp), 32'(dp));
        check({name, "_err"}, 32'(digit_err), 32'(err));
        check({name, "_frames"}, 32'(frames), 32'(nfr));
`ifdef SEG7_SCAN_ERR_CNT_EN
        check({name, "_err_count"}, 32'(err_count), 32'(errs));
`else
        if (errs < 0) $display("unexpected negative error count");
`endif
        frames = 0;
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] an;
        logic [7:0] code;
        int         cyc;
        logic       chk;
        logic [7:0] val;
        logic [1:0] dp;
        logic [1:0] err;
        int         nfr;
        int         errs;
    } step_t;

    step_t steps[$];

    initial begin
        reset = 1'b1;
        anode_n = '1;
        seg_code = 8'hFF;
        tick();
        tick();
        reset = 1'b0;

        // basic frame
        steps.push_back('{1'b0, 2'b10, 8'h40, 6, 1'b0, 8'h00, 2'b00, 2'b00, 0, 0});
        steps.push_back('{1'b0, 2'b01, 8'h0E, 6, 1'b0, 8'h00, 2'b00, 2'b00, 0, 0});
        steps.push_back('{1'b0, 2'b11, 8'hFF, 3, 1'b1, 8'hF0, 2'b11, 2'b00, 1, 0});
        // dwell too short
        steps.push_back('{1'b1, 2'b10, 8'h40, 3, 1'b0, 8'h00, 2'b00, 2'b00, 0, 0});
        for (int k = 0; k < 3; k++) begin
            steps.push_back('{1'b0, 2'b01, 8'h0E, 3, 1'b0, 8'h00, 2'b00, 2'b00, 0, 0});
            steps.push_back('{1'b0, 2'b10, 8'h40, 3, 1'b0, 8'h00, 2'b00, 2'b00, 0, 0});
        end
        steps.push_back('{1'b0, 2'b11, 8'hFF, 3, 1'b1, 8'h00, 2'b00, 2'b00, 0, 0});
        // glitch
        steps.push_back('{1'b0, 2'b10, 8'h79, 2, 1'b0, 8'h00, 2'b00, 2'b00, 0, 0});
        steps.push_back('{1'b0, 2'b10, 8'h24, 5, 1'b0, 8'h00, 2'b00, 2'b00, 0, 0});
        steps.push_back('{1'b0, 2'b01, 8'h0E, 5, 1'b0, 8'h00, 2'b00, 2'b00, 0, 0});
        steps.push_back('{1'b0, 2'b11, 8'hFF, 3, 1'b1, 8'hF2, 2'b11, 2'b00, 1, 0});
        // invalid glyph on digit1
        steps.push_back('{1'b0, 2'b10, 8'h30, 5, 1'b0, 8'h00, 2'b00, 2'b00, 0, 0});
        steps.push_back('{1'b0, 2'b01, 8'h7F, 5, 1'b0, 8'h00, 2'b00, 2'b00, 0, 0});
        steps.push_back('{1'b0, 2'b11, 8'hFF, 3, 1'b1, 8'h03, 2'b11, 2'b10, 1, 1});
        // illegal anodes: nothing captured, outputs hold
        steps.push_back('{1'b0, 2'b00, 8'h40, 10, 1'b0, 8'h00, 2'b00, 2'b00, 0, 0});
        steps.push_back('{1'b0, 2'b11, 8'h40, 10, 1'b1, 8'h03, 2'b11, 2'b10, 0, 1});
        // re-capture: last value wins, dp off for 8'hF9
        steps.push_back('{1'b0, 2'b10, 8'h40, 5, 1'b0, 8'h00, 2'b00, 2'b00, 0, 0});
        steps.push_back('{1'b0, 2'b11, 8'hFF, 2, 1'b0, 8'h00, 2'b00, 2'b00, 0, 0});
        steps.push_back('{1'b0, 2'b10, 8'hF9, 5, 1'b0, 8'h00, 2'b00, 2'b00, 0, 0});
        steps.push_back('{1'b0, 2'b01, 8'h0E, 5, 1'b0, 8'h00, 2'b00, 2'b00, 0, 0});
        steps.push_back('{1'b0, 2'b11, 8'hFF, 3, 1'b1, 8'hF1, 2'b10, 2'b00, 1, 1});

        foreach (steps[k]) begin
            if (steps[k].rst) pulse_reset();
            drive(steps[k].an, steps[k].code, steps[k].cyc);
            if (steps[k].chk)
                expect_out($sformatf("step%0d", k), steps[k].val, steps[k].dp,
                           steps[k].err, steps[k].nfr, steps[k].errs);
        end

        // reset mid-frame discards the partial frame
        pulse_reset();
        drive(2'b10, 8'h40, 6);
        pulse_reset();
        drive(2'b01, 8'h0E, 6);
        drive(2'b11, 8'hFF, 3);
        expect_out("rst_partial", 8'h00, 2'b00, 2'b00, 0, 0);
        drive(2'b10, 8'h40, 6);
        drive(2'b11, 8'hFF, 3);
        expect_out("rst_complete", 8'hF0, 2'b11, 2'b00, 1, 0);

        // random traffic against the model
        pulse_reset();
        for (int k = 0; k < 400; k++) begin
            logic [1:0] an;
            logic [7:0] code;
            case ($urandom_range(0, 5))
                0, 1:    an = 2'b10;
                2, 3:    an = 2'b01;
                4:       an = 2'b00;
                default: an = 2'b11;
            endcase
            if ($urandom_range(0, 3) == 0) code = 8'($urandom_range(0, 255));
            else code = {1'($urandom_range(0, 1)), glyph[$urandom_range(0, 15)]};
            if ($urandom_range(0, 49) == 0) pulse_reset();
            drive(an, code, $urandom_range(1, 7));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Reader side of the active-low, time-multiplexed 7-segment display bus. It monitors the anode-select and segment-code lines and recovers the hex digit (0-F) and decimal point shown on each digit position.
- Each code must be stable for a programmable dwell before it is accepted.
- Presents a consistent per-frame snapshot with a frame-valid pulse.
- Used for on-FPGA loopback self-test of the display path and for capturing display contents into debug logic.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digit positions (1..16).
- STABLE_CYCLES, 4, consecutive identical registered samples required before a capture (>=1).

Ports:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- anode_n  in  NUM_DIGITS  digit select, active-low, one-hot-low when valid.
- seg_code  in  8  segment bus, active-low; bit7 = dp, bits6:0 = g,f,e,d,c,b,a.
- digit_value  out  4*NUM_DIGITS  decoded nibble per digit; digit i occupies bits [4i+3:4i].
- digit_dp  out  NUM_DIGITS  1 = dp lit (seg_code[7]==0) at capture.
- digit_err  out  NUM_DIGITS  1 = captured bits6:0 matched none of the 16 glyphs.
- frame_valid  out  1  one-cycle pulse when a new snapshot is presented.

Behaviour:
- Input stage: anode_n and seg_code are registered once (s_anode, s_code). All decisions use the registered values.
- Pair check: a one-hot-low check on s_anode yields the index idx. A zero-hot or multi-hot s_anode is "no digit".
- FSM (3 states):
  - IDLE: no digit. Stay here while no digit; go to SETTLE when a valid one-hot-low s_anode appears, with cnt=1.
  - SETTLE: the {s_anode,s_code} pair equal to the previous cycle's pair increments cnt; any change sets cnt=1 and re-evaluates (no digit -> IDLE). When cnt reaches STABLE_CYCLES, capture and go to HOLD.
  - HOLD: at most one capture per dwell. Any change in the pair -> SETTLE with cnt=1, or IDLE if no digit.
  - With STABLE_CYCLES=1, capture occurs on the first cycle in SETTLE.
- Latency: with an input pair held from cycle 0, the capture edge is the rising edge at the end of cycle STABLE_CYCLES.
- Capture: writes shadow[idx] = {err, dp, value} and sets seen[idx].
- Glyph decode (bits6:0, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - Any other pattern: value=0, err=1.
- Frame: when the capture completes seen (all ones, counting the current capture), then on that same edge:
  - copy shadow, including the current capture, to the outputs;
  - clear seen;
  - drive frame_valid=1 for exactly the following cycle.
- Re-capture: a digit captured twice before the frame completes overwrites its shadow entry, so the last value wins.
- Output stability: outputs change only on frame edges and hold otherwise.
- Reset mid-operation: FSM returns to IDLE; cnt, seen and shadow are cleared; any partial frame is discarded.
- Reset values: digit_value=0, digit_dp=0, digit_err=0, frame_valid=0, s_anode=all ones, s_code=8'hFF.
- Simultaneous change of anode and code counts as a single change (restart).
- cnt saturates at STABLE_CYCLES and is sized $clog2(STABLE_CYCLES+1).

Optional Feature:
- Macro: SEG7_SCAN_ERR_CNT_EN.
- Defined: adds output err_count (16 bits), reset 0. It increments once per capture with err=1 and saturates at FFFF. It is cleared only by reset.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package seg7_pkg holds the 16 active-low glyph constants, shared with the existing segment encoder, and the FSM state enum {IDLE, SETTLE, HOLD}.
- One natural sub-module, seg7_glyph_decoder: purely combinational, mapping bits6:0 to {err, value}. It is instantiated once on s_code.

Test Plan:
- NUM_DIGITS=2, STABLE_CYCLES=4: drive anode_n=2'b10 with seg_code=8'h40 for 6 cycles, then 2'b01 with 8'h0E for 6 cycles. Expect:
  - one frame_valid pulse;
  - digit_value=8'hF0, digit_dp=2'b11 (bit7=0), digit_err=0.
- Dwell too short: hold each digit for 3 cycles, repeated. Expect no capture, frame_valid never asserted, outputs remain 0.
- Glitch: code 8'h79 for 2 cycles, then 8'h24 for 5 cycles on digit0. Expect digit0 value=2, not 1, after the frame.
- Invalid glyph: 8'h7F on digit1 with a valid 8'h30 on digit0. Expect digit_err=2'b10, value 8'h03. With SEG7_SCAN_ERR_CNT_EN defined, err_count=1.
- Illegal anodes: anode_n=2'b00 and then 2'b11 for 10 cycles each. Expect FSM in IDLE with no captures.
- Reset mid-frame: capture digit0, assert reset 1 cycle, then complete digit1 only. Expect no frame_valid until both digits are re-captured after reset.
